// File: rtl/tt_um_dpmu.sv
// Four-domain power management unit: per-domain power-switch / isolation / reset / retention sequencing.
// Optional retention state is built only when DPMU_RETENTION_EN is defined.

module dpmu_dom #(
    parameter int RAMP_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pmu_en,
    input  logic tgt,
    input  logic ret_sel,
    output logic pwr_en,
    output logic iso,
    output logic dom_rst_n,
    output logic ret,
    output logic on,
    output logic busy
);
    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_RAMP = 3'd1,
        S_ON   = 3'd2,
        S_ISO  = 3'd3,
        S_RET  = 3'd4
    } state_t;

    localparam logic [3:0] RAMP_LOAD = 4'(RAMP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Everything holds while pmu_en is low, including a half-finished ramp.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (pmu_en) begin
            case (state)
                S_OFF: if (tgt) begin
                    state_nxt = S_RAMP;
                    cnt_nxt   = RAMP_LOAD;
                end
                S_RAMP: begin
                    if (!tgt)
                        state_nxt = S_OFF;
                    else if (cnt == 4'd0)
                        state_nxt = S_ON;
                    else
                        cnt_nxt = cnt - 4'd1;
                end
                S_ON: if (!tgt) state_nxt = S_ISO;
                S_ISO: begin
                    if (tgt)
                        state_nxt = S_ON;
`ifdef DPMU_RETENTION_EN
                    else if (ret_sel)
                        state_nxt = S_RET;
`endif
                    else
                        state_nxt = S_OFF;
                end
                S_RET: if (tgt) begin
                    state_nxt = S_RAMP;
                    cnt_nxt   = RAMP_LOAD;
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        pwr_en    = (state == S_RAMP) || (state == S_ON) || (state == S_ISO);
        iso       = (state != S_ON);
        dom_rst_n = (state == S_ON) || (state == S_ISO) || (state == S_RET);
`ifdef DPMU_RETENTION_EN
        ret       = (state == S_RET);
`else
        ret       = 1'b0;
`endif
        on        = (state == S_ON);
        busy      = (state == S_RAMP) || (state == S_ISO);
    end

`ifndef DPMU_RETENTION_EN
    logic unused_ret_sel;
    assign unused_ret_sel = ret_sel;
`endif
endmodule

module tt_um_dpmu #(
    parameter int RAMP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NUM_DOM = 4;

    // rst_n is the tile's pin name; the reset it carries is active-high.
    logic rst;
    assign rst = rst_n;

    logic [NUM_DOM-1:0] dom_req, tgt;
    logic               sleep, ret_sel, pmu_en, status_sel;

    assign dom_req    = ui_in[7:4];
    assign sleep      = ui_in[3];
    assign ret_sel    = ui_in[2];
    assign pmu_en     = ui_in[1];
    assign status_sel = ui_in[0];
    assign tgt        = dom_req & {NUM_DOM{~sleep}};

    logic [NUM_DOM-1:0] pwr_en, iso, dom_rst_n, ret, on, busy;

    for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
        dpmu_dom #(.RAMP_CYCLES(RAMP_CYCLES)) u_dom (
            .clk       (clk),
            .rst       (rst),
            .pmu_en    (pmu_en),
            .tgt       (tgt[i]),
            .ret_sel   (ret_sel),
            .pwr_en    (pwr_en[i]),
            .iso       (iso[i]),
            .dom_rst_n (dom_rst_n[i]),
            .ret       (ret[i]),
            .on        (on[i]),
            .busy      (busy[i])
        );
    end

    assign uo_out  = {iso, pwr_en};
    assign uio_out = status_sel ? {busy, on} : {ret, dom_rst_n};
    assign uio_oe  = 8'hFF;

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, uio_in};
endmodule

// File: tb/tb_tt_um_dpmu.sv
// Directed-vector bench for tt_um_dpmu (RAMP_CYCLES = 2), with and without DPMU_RETENTION_EN.
`timescale 1ns/1ps

module tb_tt_um_dpmu;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    tt_um_dpmu #(.RAMP_CYCLES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ui_in = 8'hF2;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL reset_uo cyc%0d got=%h exp=%h", i, uo_out, 8'hF0); end
            n_cmp++;
            if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio cyc%0d got=%h exp=%h", i, uio_out, 8'h00); end
        end
        n_cmp++;
        if (uio_oe !== 8'hFF) begin n_bad++; $display("FAIL reset_oe got=%h exp=%h", uio_oe, 8'hFF); end
        ui_in = 8'hF3;
        #1;
        n_cmp++;
        if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_sel1 got=%h exp=%h", uio_out, 8'h00); end
        ui_in = 8'hF2;
    endtask

    task automatic test_power_up();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL pu_edge1_uo got=%h exp=%h", uo_out, 8'hFF); end
        n_cmp++;
        if (uio_out !== 8'h00) begin n_bad++; $display("FAIL pu_edge1_uio got=%h exp=%h", uio_out, 8'h00); end
        ui_in = 8'hF3;
        #1;
        n_cmp++;
        if (uio_out !== 8'hF0) begin n_bad++; $display("FAIL pu_busy got=%h exp=%h", uio_out, 8'hF0); end
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL pu_edge2_uo got=%h exp=%h", uo_out, 8'hFF); end
        step();
        n_cmp++;
        if (uo_out !== 8'h0F) begin n_bad++; $display("FAIL pu_edge3_uo got=%h exp=%h", uo_out, 8'h0F); end
        n_cmp++;
        if (uio_out !== 8'h0F) begin n_bad++; $display("FAIL pu_edge3_uio_sel1 got=%h exp=%h", uio_out, 8'h0F); end
        ui_in = 8'hF2;
        #1;
        n_cmp++;
        if (uio_out !== 8'h0F) begin n_bad++; $display("FAIL pu_edge3_uio_sel0 got=%h exp=%h", uio_out, 8'h0F); end
    endtask

    task automatic test_partial_off();
        ui_in = 8'h12;
        step();
        n_cmp++;
        if (uo_out !== 8'hEF) begin n_bad++; $display("FAIL poff_iso_uo got=%h exp=%h", uo_out, 8'hEF); end
        n_cmp++;
        if (uio_out !== 8'h0F) begin n_bad++; $display("FAIL poff_iso_uio got=%h exp=%h", uio_out, 8'h0F); end
        step();
        n_cmp++;
        if (uo_out !== 8'hE1) begin n_bad++; $display("FAIL poff_off_uo got=%h exp=%h", uo_out, 8'hE1); end
        n_cmp++;
        if (uio_out !== 8'h01) begin n_bad++; $display("FAIL poff_off_uio got=%h exp=%h", uio_out, 8'h01); end
        ui_in = 8'hF2;
        step();
        n_cmp++;
        if (uo_out !== 8'hEF) begin n_bad++; $display("FAIL poff_reramp_uo got=%h exp=%h", uo_out, 8'hEF); end
        step();
        step();
        n_cmp++;
        if (uo_out !== 8'h0F) begin n_bad++; $display("FAIL poff_allon_uo got=%h exp=%h", uo_out, 8'h0F); end
    endtask

    // ISO lasts one cycle and returns straight to ON when the request comes back.
    task automatic test_iso_return();
        ui_in = 8'h02;
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL isoret_iso_uo got=%h exp=%h", uo_out, 8'hFF); end
        ui_in = 8'hF3;
        #1;
        n_cmp++;
        if (uio_out !== 8'hF0) begin n_bad++; $display("FAIL isoret_busy got=%h exp=%h", uio_out, 8'hF0); end
        step();
        n_cmp++;
        if (uo_out !== 8'h0F) begin n_bad++; $display("FAIL isoret_on_uo got=%h exp=%h", uo_out, 8'h0F); end
        n_cmp++;
        if (uio_out !== 8'h0F) begin n_bad++; $display("FAIL isoret_on_uio got=%h exp=%h", uio_out, 8'h0F); end
        ui_in = 8'hF2;
    endtask

    task automatic test_retention();
        ui_in = 8'hEE;
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL ret_iso_uo got=%h exp=%h", uo_out, 8'hFF); end
        step();
`ifdef DPMU_RETENTION_EN
        n_cmp++;
        if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL ret_ret_uo got=%h exp=%h", uo_out, 8'hF0); end
        n_cmp++;
        if (uio_out !== 8'hFF) begin n_bad++; $display("FAIL ret_ret_uio got=%h exp=%h", uio_out, 8'hFF); end
        step();
        n_cmp++;
        if (uio_out !== 8'hFF) begin n_bad++; $display("FAIL ret_hold_uio got=%h exp=%h", uio_out, 8'hFF); end
        // Clearing sleep: domains 1..3 ramp, domain 0 has no request and stays in RET.
        ui_in = 8'hE6;
        step();
        n_cmp++;
        if (uo_out !== 8'hFE) begin n_bad++; $display("FAIL ret_ramp_uo got=%h exp=%h", uo_out, 8'hFE); end
        n_cmp++;
        if (uio_out !== 8'h11) begin n_bad++; $display("FAIL ret_ramp_uio got=%h exp=%h", uio_out, 8'h11); end
        step();
        n_cmp++;
        if (uo_out !== 8'hFE) begin n_bad++; $display("FAIL ret_ramp2_uo got=%h exp=%h", uo_out, 8'hFE); end
        step();
        n_cmp++;
        if (uo_out !== 8'h1E) begin n_bad++; $display("FAIL ret_on_uo got=%h exp=%h", uo_out, 8'h1E); end
        n_cmp++;
        if (uio_out !== 8'h1F) begin n_bad++; $display("FAIL ret_on_uio got=%h exp=%h", uio_out, 8'h1F); end
        ui_in = 8'hF2;
        step();
        n_cmp++;
        if (uo_out !== 8'h1F) begin n_bad++; $display("FAIL ret_d0ramp_uo got=%h exp=%h", uo_out, 8'h1F); end
        step();
        step();
`else
        n_cmp++;
        if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL noret_off_uo got=%h exp=%h", uo_out, 8'hF0); end
        n_cmp++;
        if (uio_out !== 8'h00) begin n_bad++; $display("FAIL noret_off_uio got=%h exp=%h", uio_out, 8'h00); end
        ui_in = 8'hF2;
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL noret_ramp_uo got=%h exp=%h", uo_out, 8'hFF); end
        step();
        step();
`endif
        n_cmp++;
        if (uo_out !== 8'h0F) begin n_bad++; $display("FAIL ret_allon_uo got=%h exp=%h", uo_out, 8'h0F); end
    endtask

    task automatic test_reset_mid_ramp();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        ui_in = 8'hF2;
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL rmr_ramp_uo got=%h exp=%h", uo_out, 8'hFF); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL rmr_async_uo got=%h exp=%h", uo_out, 8'hF0); end
        n_cmp++;
        if (uio_out !== 8'h00) begin n_bad++; $display("FAIL rmr_async_uio got=%h exp=%h", uio_out, 8'h00); end
        ui_in = 8'hF3;
        #1;
        n_cmp++;
        if (uio_out !== 8'h00) begin n_bad++; $display("FAIL rmr_async_uio_sel1 got=%h exp=%h", uio_out, 8'h00); end
        ui_in = 8'hF2;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_freeze();
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL frz_ramp_uo got=%h exp=%h", uo_out, 8'hFF); end
        ui_in = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL frz_hold cyc%0d got=%h exp=%h", i, uo_out, 8'hFF); end
        end
        ui_in = 8'hF2;
        step();
        n_cmp++;
        if (uo_out !== 8'hFF) begin n_bad++; $display("FAIL frz_resume_uo got=%h exp=%h", uo_out, 8'hFF); end
        step();
        n_cmp++;
        if (uo_out !== 8'h0F) begin n_bad++; $display("FAIL frz_on_uo got=%h exp=%h", uo_out, 8'h0F); end
        // Frozen in ON with all requests gone: nothing moves.
        ui_in = 8'h00;
        step();
        step();
        n_cmp++;
        if (uo_out !== 8'h0F) begin n_bad++; $display("FAIL frz_on_hold_uo got=%h exp=%h", uo_out, 8'h0F); end
    endtask

    task automatic test_abort();
        ui_in = 8'h02;
        step();
        step();
        n_cmp++;
        if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL abort_alloff_uo got=%h exp=%h", uo_out, 8'hF0); end
        ui_in = 8'h12;
        step();
        n_cmp++;
        if (uo_out !== 8'hF1) begin n_bad++; $display("FAIL abort_ramp_uo got=%h exp=%h", uo_out, 8'hF1); end
        ui_in = 8'h02;
        step();
        n_cmp++;
        if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL abort_off_uo got=%h exp=%h", uo_out, 8'hF0); end
        step();
        n_cmp++;
        if (uo_out !== 8'hF0) begin n_bad++; $display("FAIL abort_stay_uo got=%h exp=%h", uo_out, 8'hF0); end
        ui_in = 8'h03;
        #1;
        n_cmp++;
        if (uio_out !== 8'h00) begin n_bad++; $display("FAIL abort_status got=%h exp=%h", uio_out, 8'h00); end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hF2;
        uio_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_power_up();
        test_partial_off();
        test_iso_return();
        test_retention();
        test_reset_mid_ramp();
        test_freeze();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tt_um_dpmu.md
# tt_um_dpmu

Digital power management unit (DPMU) for four independently switchable power domains. It is a Tiny Tapeout user tile. Per-domain power-on requests and global sleep/retention controls arrive on `ui_in`. For each domain it sequences the power-switch enable, isolation, domain reset and retention outputs so that they always occur in a legal order.

## Interface
- `RAMP_CYCLES`, default 2: cycles a domain stays in RAMP (power switch on, still isolated and in reset). Legal range is 1..15.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-high. Reset is asserted while `rst_n`=1.
- `ena` input 1: tile select; ignored.
- `ui_in` input 8:
  - [7:4] `dom_req[3:0]`: per-domain power-on request.
  - [3] `sleep`: forces every domain off.
  - [2] `ret_sel`: power-down goes to retention.
  - [1] `pmu_en`: when 0, all sequencers freeze.
  - [0] `status_sel`: selects the `uio_out` view.
- `uio_in` input 8: unused.
- `uo_out` output 8: [3:0] `pwr_en[3:0]`; [7:4] `iso[3:0]` (1 = isolated).
- `uio_out` output 8:
  - When `status_sel`=0: {`ret[3:0]`, `dom_rst_n[3:0]`}.
  - When `status_sel`=1: {`busy[3:0]`, `on[3:0]`}.
- `uio_oe` output 8: constant 8'hFF.

## Operation
- Per-domain target: `tgt[i] = dom_req[i] & ~sleep`.
- Each domain runs an identical Moore FSM with a 4-bit ramp counter.
- Domain states and outputs (`pwr_en`/`iso`/`dom_rst_n`/`ret`):
  - OFF 0/1/0/0.
  - RAMP 1/1/0/0.
  - ON 1/0/1/0.
  - ISO 1/1/1/0.
  - RET 0/1/1/1.
- Transitions, evaluated only when `pmu_en`=1:
  - OFF: if `tgt`, go to RAMP and load counter = `RAMP_CYCLES`-1.
  - RAMP: if `!tgt`, abort to OFF. Else if counter = 0, go to ON. Else decrement.
  - ON: if `!tgt`, go to ISO.
  - ISO (always exactly one cycle):
    - If `tgt`, return to ON.
    - Else if `ret_sel`, go to RET.
    - Else go to OFF.
  - RET: if `tgt`, go to RAMP (counter loaded as from OFF).
- `pmu_en`=0: states and counters hold; outputs are unchanged.
- `on[i]` = state is ON. `busy[i]` = state is RAMP or ISO.
- Domains are independent; simultaneous transitions in several domains are legal.
- `status_sel` is a combinational mux only and has no effect on sequencing.

## Timing
- `ui_in` is sampled at each rising edge. `uo_out` and `uio_out` are decoded from registered state and change only after the edge on which the state changes. The exception is the `status_sel` mux, which is combinational.
- Power-up: `tgt` high before edge k gives RAMP after edge k and ON after edge k+`RAMP_CYCLES`.
- Power-down: `tgt` low before edge k gives ISO after edge k, then OFF or RET after edge k+1.
- Invariant: `iso`=1 whenever `pwr_en`=0 or `dom_rst_n`=0. `iso` never drops while in RAMP.
- Reset (async, any state, including mid-RAMP): all domains go to OFF and counters clear to 0.
  - `uo_out`=8'hF0.
  - `uio_out`=8'h00 for either value of `status_sel`.
  - `uio_oe`=8'hFF.
- First transition after reset release happens on the first rising edge with `rst_n`=0.

## Configuration
- `DPMU_RETENTION_EN` defined: the RET state exists as specified.
- Without `DPMU_RETENTION_EN`:
  - `ret_sel` is ignored and ISO always goes to OFF.
  - RET is unreachable and `ret[3:0]` is constant 0.

## Test plan
- Reset: hold `rst_n`=1 with `ui_in`=8'hF2 -> `uo_out`=8'hF0 and `uio_out`=8'h00 throughout.
- Power-up: release reset with `ui_in`=8'hF2 (`RAMP_CYCLES`=2):
  - After edge 1, `uo_out`=8'hFF.
  - After edge 3, `uo_out`=8'h0F and `uio_out`=8'h0F.
  - Setting `ui_in`=8'hF3 then gives `uio_out`=8'h0F.
- Partial off: from all ON, apply `ui_in`=8'h12 -> domains 1..3 go to ISO (`uo_out`=8'hEF), then OFF (`uo_out`=8'hE1, `uio_out`=8'h01).
- Retention (macro defined): from all ON, apply `ui_in`=8'hEE (`sleep`, `ret_sel`) -> ISO, then RET with `uo_out`=8'hF0 and `uio_out`=8'hFF. Clearing `sleep` gives RAMP, then ON after 2 cycles.
- Freeze: drop `pmu_en` mid-RAMP -> outputs hold 8'hFF; on restoring `pmu_en`, ON follows after the remaining count.
- Abort: deassert `dom_req[0]` during RAMP -> domain 0 returns to OFF on the next edge, with no ON cycle.
